// File: rtl/note_screen_pkg.sv
// Shared types and constants for the note highway drawer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package note_screen_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  localparam logic [2:0] COLOUR_BG  = 3'b000;
  localparam logic [2:0] COLOUR_HIT = 3'b111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_DRAW  = S_DRAW,
    ST_CLEAR = S_CLEAR,
    ST_DONE  = S_DONE
  } state_t;

  // Counter width for a 0..n-1 index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Note colour per lane; the four-entry table repeats for wider highways.
  function automatic logic [2:0] lane_colour(input int lane);
    logic [2:0] c;
    case (lane % 4)
      0:       c = 3'b100;
      1:       c = 3'b010;
      2:       c = 3'b001;
      default: c = 3'b110;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cell_pixel_walker.sv
// Nested px/py/lane/row scan counters for one full pass over the grid.
// Latency: indices move one step the cycle after advance_i; clear_i zeroes them next cycle.
// Backpressure: none; the counters only move when advance_i is high.
module cell_pixel_walker
  import note_screen_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ROWS   = 8,
  parameter int CELL_W = 8,
  parameter int CELL_H = 8,
  parameter int PX_W   = idx_w(CELL_W),
  parameter int PY_W   = idx_w(CELL_H),
  parameter int LN_W   = idx_w(LANES),
  parameter int RW_W   = idx_w(ROWS)
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            clear_i,
  input  logic            advance_i,
  output logic [PX_W-1:0] px_o,
  output logic [PY_W-1:0] py_o,
  output logic [LN_W-1:0] lane_o,
  output logic [RW_W-1:0] row_o,
  output logic            last_o
);

  localparam logic [PX_W-1:0] PX_MAX = PX_W'(CELL_W - 1);
  localparam logic [PY_W-1:0] PY_MAX = PY_W'(CELL_H - 1);
  localparam logic [LN_W-1:0] LN_MAX = LN_W'(LANES - 1);
  localparam logic [RW_W-1:0] RW_MAX = RW_W'(ROWS - 1);

  logic [PX_W-1:0] px_q, px_d;
  logic [PY_W-1:0] py_q, py_d;
  logic [LN_W-1:0] lane_q, lane_d;
  logic [RW_W-1:0] row_q, row_d;

  // Odometer step: px innermost, row outermost, wrapping to zero after the last pixel.
  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    lane_d = lane_q;
    row_d  = row_q;
    if (advance_i) begin
      if (px_q != PX_MAX) begin
        px_d = px_q + 1'b1;
      end else begin
        px_d = '0;
        if (py_q != PY_MAX) begin
          py_d = py_q + 1'b1;
        end else begin
          py_d = '0;
          if (lane_q != LN_MAX) begin
            lane_d = lane_q + 1'b1;
          end else begin
            lane_d = '0;
            row_d  = (row_q != RW_MAX) ? row_q + 1'b1 : '0;
          end
        end
      end
    end
  end

  // Counter registers; clear wins over advance.
  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      px_q   <= '0;
      py_q   <= '0;
      lane_q <= '0;
      row_q  <= '0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      lane_q <= lane_d;
      row_q  <= row_d;
    end
  end

  assign px_o   = px_q;
  assign py_o   = py_q;
  assign lane_o = lane_q;
  assign row_o  = row_q;
  assign last_o = (px_q == PX_MAX) && (py_q == PY_MAX) && (lane_q == LN_MAX) && (row_q == RW_MAX);

endmodule

// File: rtl/note_screen_drawer.sv
// Repaints the note highway one pixel per cycle after each beat, or blanks it when the song ends.
// Latency: first pixel the cycle after the trigger, last pixel LANES*ROWS*CELL_W*CELL_H cycles after it.
// Backpressure: none on the pixel stream; readyForSong stays low until the repaint and DONE cycle finish.
module note_screen_drawer
  import note_screen_pkg::*;
#(
  parameter int             LANES  = 4,
  parameter int             ROWS   = 8,
  parameter int             CELL_W = 8,
  parameter int             CELL_H = 8,
  parameter logic [X_W-1:0] X0     = 8'd16,
  parameter logic [Y_W-1:0] Y0     = 7'd8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  beatIncremented,
  input  logic                  songDone,
  input  logic [LANES*ROWS-1:0] noteGrid,
  output logic                  readyForSong,
  output logic [X_W-1:0]        x,
  output logic [Y_W-1:0]        y,
  output logic [2:0]            colour,
  output logic                  plot,
  output logic                  overrun
);

  localparam int PX_W = idx_w(CELL_W);
  localparam int PY_W = idx_w(CELL_H);
  localparam int LN_W = idx_w(LANES);
  localparam int RW_W = idx_w(ROWS);
  localparam int NB   = LANES * ROWS;

  state_t          state_q, state_d;
  logic [NB-1:0]   grid_q, grid_d;
  logic            song_q;
  logic            overrun_q, overrun_d;
  logic            end_q, end_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [2:0]      colour_q, colour_d;
  logic            plot_q, plot_d;

  logic            walk_clr, walk_adv, emit;
  logic [PX_W-1:0] w_px;
  logic [PY_W-1:0] w_py;
  logic [LN_W-1:0] w_lane;
  logic [RW_W-1:0] w_row;
  logic            w_last;

  logic            song_rise;
  logic [NB-1:0]   src_grid, bit_mask;
  logic            paint, note_on;
  logic [X_W-1:0]  pix_x;
  logic [Y_W-1:0]  pix_y;
  logic [2:0]      pix_colour;

  cell_pixel_walker #(
    .LANES (LANES),
    .ROWS  (ROWS),
    .CELL_W(CELL_W),
    .CELL_H(CELL_H),
    .PX_W  (PX_W),
    .PY_W  (PY_W),
    .LN_W  (LN_W),
    .RW_W  (RW_W)
  ) u_walker (
    .clock_i  (clock),
    .reset_i  (reset),
    .clear_i  (walk_clr),
    .advance_i(walk_adv),
    .px_o     (w_px),
    .py_o     (w_py),
    .lane_o   (w_lane),
    .row_o    (w_row),
    .last_o   (w_last)
  );

  assign song_rise = songDone & ~song_q;

  // Pixel for the walker's current index. In IDLE the trigger cycle is being decoded, so the
  // live noteGrid (the value about to be latched) feeds the very first pixel.
  always_comb begin
    src_grid   = (state_q == ST_IDLE) ? noteGrid : grid_q;
    paint      = (state_q == ST_IDLE) ? beatIncremented : (state_q == ST_DRAW);
    bit_mask   = NB'(1) << (int'(w_row) * LANES + int'(w_lane));
    note_on    = |(src_grid & bit_mask);
    pix_x      = X0 + X_W'(int'(w_lane) * CELL_W) + X_W'(w_px);
    pix_y      = Y0 + Y_W'(int'(w_row) * CELL_H) + Y_W'(w_py);
    pix_colour = COLOUR_BG;
    if (paint) begin
      if (note_on) begin
        pix_colour = lane_colour(int'(w_lane));
      end else if (w_row == RW_W'(ROWS - 1)) begin
        pix_colour = COLOUR_HIT;
      end
    end
  end

  // Next state and output registers. end_q marks that the last pixel is on the bus now, so the
  // following edge drops plot and enters DONE.
  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    overrun_d = overrun_q | (beatIncremented && (state_q != ST_IDLE));
    end_d     = end_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    walk_clr  = 1'b0;
    walk_adv  = 1'b0;
    emit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        walk_clr = 1'b1;
        end_d    = 1'b0;
        if (beatIncremented) begin
          grid_d  = noteGrid;
          state_d = ST_DRAW;
          emit    = 1'b1;
        end else if (song_rise) begin
          state_d = ST_CLEAR;
          emit    = 1'b1;
        end
      end
      ST_DRAW, ST_CLEAR: begin
        if (end_q) begin
          state_d  = ST_DONE;
          walk_clr = 1'b1;
          end_d    = 1'b0;
        end else begin
          emit = 1'b1;
        end
      end
      ST_DONE: begin
        walk_clr = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (emit) begin
      walk_clr = 1'b0;
      walk_adv = 1'b1;
      plot_d   = 1'b1;
      x_d      = pix_x;
      y_d      = pix_y;
      colour_d = pix_colour;
      end_d    = w_last;
    end
  end

  // State, latch and registered pixel outputs; songDone history starts high to avoid a false edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grid_q    <= '0;
      song_q    <= 1'b1;
      overrun_q <= 1'b0;
      end_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      song_q    <= songDone;
      overrun_q <= overrun_d;
      end_q     <= end_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
    end
  end

  assign readyForSong = (state_q == ST_IDLE);
  assign x            = x_q;
  assign y            = y_q;
  assign colour       = colour_q;
  assign plot         = plot_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_note_screen_drawer.sv
// Bench for note_screen_drawer at default parameters.
// Latency: checks first/last pixel timing and the readyForSong window around each repaint.
// Backpressure: n/a.
module tb_note_screen_drawer;

  logic        clock = 1'b0;
  logic        reset;
  logic        beatIncremented;
  logic        songDone;
  logic [31:0] noteGrid;
  logic        readyForSong;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [2:0] frame [0:255][0:127];

  always #5 clock = ~clock;

  note_screen_drawer dut (
    .clock          (clock),
    .reset          (reset),
    .beatIncremented(beatIncremented),
    .songDone       (songDone),
    .noteGrid       (noteGrid),
    .readyForSong   (readyForSong),
    .x              (x),
    .y              (y),
    .colour         (colour),
    .plot           (plot),
    .overrun        (overrun)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected colour of a screen pixel, from the highway picture: which cell it lies in.
  function automatic logic [2:0] ref_colour(input int px, input int py, input logic [31:0] g,
                                             input bit paint);
    int lane;
    int row;
    lane = (px - 16) / 8;
    row  = (py - 8) / 8;
    if (!paint) return 3'b000;
    if (g[row * 4 + lane]) begin
      case (lane)
        0:       return 3'b100;
        1:       return 3'b010;
        2:       return 3'b001;
        default: return 3'b110;
      endcase
    end
    return (row == 7) ? 3'b111 : 3'b000;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 128; j++)
        frame[i][j] = 3'bxxx;
  endtask

  // Watches cycles N+1..N+2060 after a trigger at cycle N. The n-th plotted pixel must be the
  // n-th cell pixel in raster-of-cells order with the colour of the picture drawn from g.
  task automatic observe_draw(input string tag, input logic [31:0] g, input bit paint,
                              input int change_at, input int beat_at, input int song_at);
    int n_plot, n_bad, first_k, last_k, ready_bad, ex, ey;
    logic [2:0] ec;
    n_plot = 0; n_bad = 0; first_k = -1; last_k = -1; ready_bad = 0;
    clear_frame();
    for (int k = 1; k <= 2060; k++) begin
      if (plot === 1'b1) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        ex = 16 + (n_plot % 8) + 8 * ((n_plot / 64) % 4);
        ey = 8 + ((n_plot / 8) % 8) + 8 * (n_plot / 256);
        ec = ref_colour(ex, ey, g, paint);
        if (x !== 8'(ex) || y !== 7'(ey) || colour !== ec) n_bad++;
        frame[x][y] = colour;
        n_plot++;
      end
      if ((k <= 2049 && readyForSong !== 1'b0) || (k >= 2050 && readyForSong !== 1'b1))
        ready_bad++;
      beatIncremented = (k == beat_at);
      if (k == change_at) noteGrid = $urandom;
      if (k == song_at) songDone = 1'b1;
      tick();
    end
    chk({tag, " plot count"}, n_plot, 2048);
    chk({tag, " first plot cycle"}, first_k, 1);
    chk({tag, " last plot cycle"}, last_k, 2048);
    chk({tag, " bad pixels"}, n_bad, 0);
    chk({tag, " readyForSong window"}, ready_bad, 0);
  endtask

  task automatic beat_now(input logic [31:0] g);
    noteGrid = g;
    beatIncremented = 1'b1;
    tick();
    beatIncremented = 1'b0;
  endtask

  initial begin
    int idle_bad;
    logic [31:0] g;

    reset = 1'b1; beatIncremented = 1'b0; songDone = 1'b0; noteGrid = '0;
    tick(); tick(); tick();
    chk("reset plot", plot, 0);
    chk("reset x", x, 0);
    chk("reset y", y, 0);
    chk("reset colour", colour, 0);
    chk("reset overrun", overrun, 0);
    chk("reset ready", readyForSong, 1);
    reset = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (readyForSong !== 1'b1 || plot !== 1'b0 || overrun !== 1'b0) idle_bad++;
    end
    chk("idle quiet", idle_bad, 0);

    // Empty window: only the hit row lights up.
    beat_now(32'h0);
    observe_draw("empty", 32'h0, 1'b1, -1, -1, -1);
    chk("empty first px colour", frame[16][8], 0);
    chk("empty hit row start", frame[16][64], 3'b111);
    chk("empty last px colour", frame[47][71], 3'b111);
    chk("empty overrun", overrun, 0);

    // Corner notes, with noteGrid scrambled mid-draw.
    g = 32'h8000_0001;
    beat_now(g);
    observe_draw("corners", g, 1'b1, 700, -1, -1);
    chk("corner lane0 row0", frame[20][10], 3'b100);
    chk("corner lane3 hit row", frame[44][68], 3'b110);
    chk("corner lane1 row0", frame[24][8], 3'b000);

    // Second beat mid-draw: flagged, ignored, no redraw.
    g = $urandom;
    beat_now(g);
    observe_draw("overrun", g, 1'b1, -1, 100, -1);
    chk("overrun set", overrun, 1);

    // songDone rising during a draw is ignored and leaves no deferred clear.
    g = $urandom;
    beat_now(g);
    observe_draw("song mid draw", g, 1'b1, -1, -1, 300);
    songDone = 1'b0;
    tick(); tick();
    chk("overrun sticky", overrun, 1);

    // songDone rise in IDLE blanks everything, hit row included.
    songDone = 1'b1;
    tick();
    observe_draw("clear", 32'hFFFF_FFFF, 1'b0, -1, -1, -1);
    chk("clear hit row", frame[16][64], 0);
    songDone = 1'b0;
    tick(); tick();

    // Beat and songDone rise together: the beat wins.
    g = $urandom;
    noteGrid = g;
    songDone = 1'b1;
    beatIncremented = 1'b1;
    tick();
    beatIncremented = 1'b0;
    observe_draw("beat beats clear", g, 1'b1, -1, -1, -1);
    songDone = 1'b0;
    tick(); tick();

    // Reset at draw cycle 500.
    beat_now($urandom);
    for (int k = 1; k < 500; k++) tick();
    chk("pre-reset plotting", plot, 1);
    reset = 1'b1;
    tick();
    chk("mid reset plot", plot, 0);
    chk("mid reset ready", readyForSong, 1);
    chk("mid reset overrun", overrun, 0);
    reset = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (plot !== 1'b0) idle_bad++;
    end
    chk("no pixels after reset", idle_bad, 0);
    g = $urandom;
    beat_now(g);
    observe_draw("after reset", g, 1'b1, -1, -1, -1);

    // A few more random windows.
    for (int r = 0; r < 3; r++) begin
      g = $urandom;
      beat_now(g);
      observe_draw("random", g, 1'b1, 1000 + r, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
